// File: rtl/ext_mem_arb_pkg.sv
// rtl/ext_mem_arb_pkg.sv - shared types and constants for the external-memory arbiter
package ext_mem_arb_pkg;

  // Pad-sequencing FSM states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    RWAIT = 3'd3,
    ACK   = 3'd4
  } arb_state_e;

  // Requester identity; also the encoding of the round-robin last grant
  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_e;

  // Width of the read-wait down-counter (READ_WAIT is 1..15)
  localparam int RW_CNT_W = 4;

  // Value loaded into the read-wait counter on entry to RWAIT
  function automatic logic [RW_CNT_W-1:0] rw_load(input int read_wait);
    return RW_CNT_W'(read_wait - 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with a last-grant register
module rr_arb2
  import ext_mem_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    cpu_req_i,
  input  logic    host_req_i,
  input  logic    advance_i,
  input  req_id_e adv_id_i,
  output logic    gnt_valid_o,
  output req_id_e gnt_id_o
);

  req_id_e last_q;
  req_id_e last_d;

  // Last-grant register: starts as CPU so the host wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_CPU;
    end else begin
      last_q <= last_d;
    end
  end

  // Record the completed grant only when the transaction is acknowledged
  always_comb begin
    last_d = last_q;
    if (advance_i) begin
      last_d = adv_id_i;
    end
  end

  // Grant: a lone request wins; on a tie the port not served last wins
  always_comb begin
    gnt_valid_o = cpu_req_i | host_req_i;
    gnt_id_o    = REQ_CPU;
    if (cpu_req_i && host_req_i) begin
      if (last_q == REQ_CPU) begin
        gnt_id_o = REQ_HOST;
      end else begin
        gnt_id_o = REQ_CPU;
      end
    end else if (host_req_i) begin
      gnt_id_o = REQ_HOST;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// rtl/ext_mem_arbiter.sv - CPU/host arbiter and pad sequencer for the external memory bus
module ext_mem_arbiter
  import ext_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int READ_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] bus_out,
  output logic [ADDR_W-1:0] bus_oe,
  output logic              mar_we,
  output logic              ram_we,
  output logic              busy
);

  localparam logic [RW_CNT_W-1:0] RW_LOAD = rw_load(READ_WAIT);
  localparam logic [ADDR_W-1:0]   DATA_OE = {{(ADDR_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  arb_state_e          state_q, state_d;
  req_id_e             id_q, id_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [RW_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;

  logic [ADDR_W-1:0]   bus_out_q, bus_out_d;
  logic [ADDR_W-1:0]   bus_oe_q, bus_oe_d;
  logic                mar_we_q, mar_we_d;
  logic                ram_we_q, ram_we_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                host_ack_q, host_ack_d;
  logic                busy_q, busy_d;

  logic                gnt_valid;
  req_id_e             gnt_id;
  logic                advance;

  rr_arb2 u_rr_arb2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_req_i   (cpu_req),
    .host_req_i  (host_req),
    .advance_i   (advance),
    .adv_id_i    (id_q),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id)
  );

  // Next state: latch the winner in IDLE, then walk the pad phases on the latched copy
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    advance      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d = ADDR;
          id_d    = gnt_id;
          if (gnt_id == REQ_HOST) begin
            we_d    = host_we;
            addr_d  = host_addr;
            wdata_d = host_wdata;
          end else begin
            we_d    = cpu_we;
            addr_d  = cpu_addr;
            wdata_d = cpu_wdata;
          end
        end
      end
      ADDR: begin
        if (we_q) begin
          state_d = WDATA;
        end else begin
          state_d = RWAIT;
          cnt_d   = RW_LOAD;
        end
      end
      WDATA: begin
        state_d = ACK;
      end
      RWAIT: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          if (id_q == REQ_HOST) begin
            host_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
        advance = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pad drive and acks decoded from the next state so they leave a flop directly
  always_comb begin
    bus_out_d  = '0;
    bus_oe_d   = '0;
    mar_we_d   = 1'b0;
    ram_we_d   = 1'b0;
    cpu_ack_d  = (state_d == ACK) && (id_d == REQ_CPU);
    host_ack_d = (state_d == ACK) && (id_d == REQ_HOST);
    busy_d     = (state_d != IDLE);
    case (state_d)
      ADDR: begin
        bus_out_d = addr_d;
        bus_oe_d  = '1;
        mar_we_d  = 1'b1;
      end
      WDATA: begin
        bus_out_d = ADDR_W'(wdata_d);
        bus_oe_d  = DATA_OE;
        ram_we_d  = 1'b1;
      end
      default: begin
        bus_out_d = '0;
      end
    endcase
  end

  // FSM, transaction latches, counter and read-data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      id_q         <= REQ_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Registered pad outputs and acks; reset clears them immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out_q  <= '0;
      bus_oe_q   <= '0;
      mar_we_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      cpu_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      bus_out_q  <= bus_out_d;
      bus_oe_q   <= bus_oe_d;
      mar_we_q   <= mar_we_d;
      ram_we_q   <= ram_we_d;
      cpu_ack_q  <= cpu_ack_d;
      host_ack_q <= host_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign bus_out    = bus_out_q;
  assign bus_oe     = bus_oe_q;
  assign mar_we     = mar_we_q;
  assign ram_we     = ram_we_q;
  assign cpu_ack    = cpu_ack_q;
  assign host_ack   = host_ack_q;
  assign busy       = busy_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb/tb_ext_mem_arbiter.sv - self-checking bench for ext_mem_arbiter
module tb_ext_mem_arbiter;

  localparam int RW  = 2;
  localparam int RW5 = 5;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, host_req, host_we;
  logic [15:0] cpu_addr, host_addr;
  logic [7:0]  cpu_wdata, host_wdata, mem_rdata;
  logic        cpu_ack, host_ack, mar_we, ram_we, busy;
  logic [7:0]  cpu_rdata, host_rdata;
  logic [15:0] bus_out, bus_oe;

  logic        cpu2_req, cpu2_we, host2_req, host2_we;
  logic [15:0] cpu2_addr, host2_addr;
  logic [7:0]  cpu2_wdata, host2_wdata, mem2_rdata;
  logic        cpu2_ack, host2_ack, mar2_we, ram2_we, busy2;
  logic [7:0]  cpu2_rdata, host2_rdata;
  logic [15:0] bus2_out, bus2_oe;

  ext_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_WAIT(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_rdata(mem_rdata), .bus_out(bus_out), .bus_oe(bus_oe),
    .mar_we(mar_we), .ram_we(ram_we), .busy(busy)
  );

  ext_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .READ_WAIT(RW5)) dut_rw5 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu2_req), .cpu_we(cpu2_we), .cpu_addr(cpu2_addr), .cpu_wdata(cpu2_wdata),
    .cpu_ack(cpu2_ack), .cpu_rdata(cpu2_rdata),
    .host_req(host2_req), .host_we(host2_we), .host_addr(host2_addr), .host_wdata(host2_wdata),
    .host_ack(host2_ack), .host_rdata(host2_rdata),
    .mem_rdata(mem2_rdata), .bus_out(bus2_out), .bus_oe(bus2_oe),
    .mar_we(mar2_we), .ram_we(ram2_we), .busy(busy2)
  );

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rval;
  } vec_t;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  rdata;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [15:0] last_addr_seen = '0;
  logic [7:0]  m_cpu_rdata = '0;
  logic [7:0]  m_host_rdata = '0;
  vec_t        vecs[6];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic we, input logic [15:0] addr,
                          input logic [7:0] rdata);
    exp_t e;
    e.port  = port;
    e.we    = we;
    e.addr  = addr;
    e.rdata = rdata;
    sb.push_back(e);
  endtask

  // Scoreboard: every ack must match the next expected transaction in order
  always @(negedge clk) begin
    exp_t e;
    if (mar_we) last_addr_seen = bus_out;
    if (cpu_ack || host_ack) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_ack: got cpu_ack=%0b host_ack=%0b expected none", cpu_ack, host_ack);
      end else begin
        e = sb.pop_front();
        chk("sb_port", 32'({host_ack, cpu_ack}), e.port ? 32'd2 : 32'd1);
        chk("sb_addr", 32'(last_addr_seen), 32'(e.addr));
        if (!e.we) chk("sb_rdata", e.port ? 32'(host_rdata) : 32'(cpu_rdata), 32'(e.rdata));
      end
    end
  end

  task automatic reset_pulse();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    m_cpu_rdata  = '0;
    m_host_rdata = '0;
  endtask

  // One isolated transaction on the default DUT, checked phase by phase
  task automatic run_txn(input vec_t v);
    push_exp(v.port, v.we, v.addr, v.rval);
    @(negedge clk);
    if (v.port) begin
      host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    @(negedge clk);
    chk("addr_bus", 32'(bus_out), 32'(v.addr));
    chk("addr_oe", 32'(bus_oe), 32'hFFFF);
    chk("addr_strobes", 32'({mar_we, ram_we, busy}), 32'b101);
    if (v.we) begin
      @(negedge clk);
      chk("wdata_bus", 32'(bus_out), 32'(v.wdata));
      chk("wdata_oe", 32'(bus_oe), 32'h00FF);
      chk("wdata_strobes", 32'({mar_we, ram_we}), 32'b01);
    end else begin
      for (int k = 0; k < RW; k++) begin
        @(negedge clk);
        chk("rwait_bus", 32'({bus_out, bus_oe}), 32'h0);
        chk("rwait_noack", 32'({cpu_ack, host_ack}), 32'h0);
        mem_rdata = (k == RW - 1) ? v.rval : (v.rval ^ 8'hFF);
      end
    end
    @(negedge clk);
    chk("ack_pulse", 32'({host_ack, cpu_ack}), v.port ? 32'd2 : 32'd1);
    if (!v.we) begin
      if (v.port) m_host_rdata = v.rval;
      else        m_cpu_rdata  = v.rval;
    end
    chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(m_cpu_rdata));
    chk("host_rdata_hold", 32'(host_rdata), 32'(m_host_rdata));
    if (v.port) host_req = 1'b0;
    else        cpu_req  = 1'b0;
    @(negedge clk);
    chk("idle_after_ack", 32'({busy, cpu_ack, host_ack}), 32'h0);
  endtask

  initial begin
    int n_c, n_h, n_acks, busy_low;
    logic started;

    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    mem_rdata = '0;
    cpu2_req = 0; cpu2_we = 0; cpu2_addr = '0; cpu2_wdata = '0;
    host2_req = 0; host2_we = 0; host2_addr = '0; host2_wdata = '0;
    mem2_rdata = '0;

    vecs[0] = '{1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, 8'h00, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 16'hBEEF, 8'h00, 8'h5A};
    vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 16'hA5A5, 8'h00, 8'hC3};

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("reset_pads", 32'({bus_out, bus_oe}), 32'h0);
    chk("reset_ctl", 32'({mar_we, ram_we, busy, cpu_ack, host_ack}), 32'h0);
    chk("reset_rdata", 32'({cpu_rdata, host_rdata}), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({busy, mar_we, busy2}), 32'h0);

    // READ_WAIT=5 CPU read: ack seven cycles after the request edge
    @(negedge clk);
    cpu2_req = 1'b1; cpu2_we = 1'b0; cpu2_addr = 16'h0777;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("rw5_addr", 32'({mar2_we, bus2_out}), 32'h10777);
      end else if (k <= 6) begin
        chk("rw5_oe", 32'(bus2_oe), 32'h0);
        chk("rw5_noack", 32'(cpu2_ack), 32'h0);
        mem2_rdata = (k == 6) ? 8'h6B : (8'hE0 + 8'(k));
      end else begin
        chk("rw5_ack", 32'({host2_ack, cpu2_ack}), 32'd1);
        chk("rw5_rdata", 32'(cpu2_rdata), 32'h6B);
        cpu2_req = 1'b0;
      end
    end

    // Table-driven isolated transactions
    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Tie right after reset: grant order host, cpu, host, cpu
    reset_pulse();
    push_exp(1'b1, 1'b1, 16'h2000, 8'h00);
    push_exp(1'b0, 1'b1, 16'h1000, 8'h00);
    push_exp(1'b1, 1'b1, 16'h2001, 8'h00);
    push_exp(1'b0, 1'b1, 16'h1001, 8'h00);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1000; cpu_wdata = 8'h11;
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h2000; host_wdata = 8'h22;
    n_c = 0; n_h = 0;
    for (int cyc = 0; cyc < 40 && (n_c < 2 || n_h < 2); cyc++) begin
      @(negedge clk);
      if (cpu_ack) begin
        n_c++;
        if (n_c < 2) begin cpu_addr = 16'h1001; cpu_wdata = 8'h12; end
        else cpu_req = 1'b0;
      end
      if (host_ack) begin
        n_h++;
        if (n_h < 2) begin host_addr = 16'h2001; host_wdata = 8'h23; end
        else host_req = 1'b0;
      end
    end
    chk("tie_cpu_acks", 32'(n_c), 32'd2);
    chk("tie_host_acks", 32'(n_h), 32'd2);
    repeat (3) @(negedge clk);

    // Continuous CPU reads with a host write arriving mid-read
    push_exp(1'b0, 1'b0, 16'h0100, 8'h77);
    push_exp(1'b1, 1'b1, 16'h3000, 8'h00);
    push_exp(1'b0, 1'b0, 16'h0101, 8'h88);
    mem_rdata = 8'h77;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100;
    n_c = 0; n_acks = 0; busy_low = 0; started = 1'b0;
    for (int cyc = 0; cyc < 60 && n_acks < 3; cyc++) begin
      @(negedge clk);
      if (busy) started = 1'b1;
      else if (started) busy_low++;
      if (cyc == 1) begin
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h3000; host_wdata = 8'h5E;
      end
      if (cpu_ack) begin
        n_acks++; n_c++;
        if (n_c == 1) begin cpu_addr = 16'h0101; mem_rdata = 8'h88; end
        else cpu_req = 1'b0;
      end
      if (host_ack) begin
        n_acks++;
        host_req = 1'b0;
      end
    end
    chk("cont_acks", 32'(n_acks), 32'd3);
    chk("cont_busy_gaps", 32'(busy_low), 32'd2);
    m_cpu_rdata = 8'h88;
    repeat (2) @(negedge clk);

    // Reset during WDATA of a host write; request held through reset
    push_exp(1'b1, 1'b1, 16'h4444, 8'h00);
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h4444; host_wdata = 8'h99;
    @(negedge clk);
    chk("rst_mid_addr", 32'({mar_we, bus_out}), 32'h14444);
    @(negedge clk);
    chk("rst_mid_wdata", 32'({ram_we, bus_out}), 32'h10099);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pads", 32'({bus_out, bus_oe}), 32'h0);
    chk("rst_async_ctl", 32'({mar_we, ram_we, busy, cpu_ack, host_ack}), 32'h0);
    chk("rst_async_rdata", 32'({cpu_rdata, host_rdata}), 32'h0);
    m_cpu_rdata = '0;
    @(negedge clk);
    chk("rst_held_ctl", 32'({mar_we, ram_we, busy, host_ack}), 32'h0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_addr", 32'({mar_we, bus_out}), 32'h14444);
    @(negedge clk);
    chk("rst_restart_wdata", 32'({ram_we, bus_oe}), 32'h100FF);
    @(negedge clk);
    chk("rst_restart_ack", 32'({host_ack, cpu_ack}), 32'd2);
    host_req = 1'b0;
    repeat (3) @(negedge clk);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ext_mem_arbiter.md
# ext_mem_arbiter

Arbitrates the chip's shared external-memory pad interface (16-bit bus, MAR write strobe, RAM write strobe, 8-bit read-data input) between the SAP-3 core and a host loader/debug port. It serializes each granted request into the pad-level address phase, data phase and read wait, and returns a one-cycle acknowledge to the granted requester. It sits between `top`'s memory port and the pad-level `uio_out`/`uio_oe`/`uo_out[1:0]`/`ui_in` mapping in the chip wrapper.

## Interface
- `ADDR_W`, 16, address width; also the pad bus width.
- `DATA_W`, 8, data width; occupies pad bus bits [DATA_W-1:0].
- `READ_WAIT`, 2, cycles the bus is released before read data is sampled; legal range 1..15.
- `clk  in  1`  clock; all logic rises on posedge.
- `rst_n  in  1`  asynchronous, active-low reset.
- `cpu_req  in  1`  CPU request; held high with stable fields until `cpu_ack`.
- `cpu_we  in  1`  1 = write, 0 = read.
- `cpu_addr  in  ADDR_W`  CPU address.
- `cpu_wdata  in  DATA_W`  CPU write data.
- `cpu_ack  out  1`  one-cycle completion pulse.
- `cpu_rdata  out  DATA_W`  read data; valid while `cpu_ack` is high and held until the next CPU read completes.
- `host_req`, `host_we`, `host_addr`, `host_wdata`, `host_ack`, `host_rdata`: same as the CPU set, for the host port.
- `mem_rdata  in  DATA_W`  pad read data (`ui_in`).
- `bus_out  out  ADDR_W`  pad bus drive value.
- `bus_oe  out  ADDR_W`  per-bit output enable; active high.
- `mar_we  out  1`  external MAR load strobe.
- `ram_we  out  1`  external RAM write strobe.
- `busy  out  1`  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ADDR, WDATA, RWAIT, ACK.
- **IDLE**
  - Sample requests and pick a winner.
  - Latch the winner's id, we, addr and wdata into internal registers; all later phases use the latched copy.
  - Any request present -> ADDR.
- **Arbitration**
  - Two-way round-robin.
  - A lone request always wins.
  - On simultaneous requests, the requester not granted last wins.
  - After reset, the last grant is CPU, so the host wins the first tie.
- **ADDR** (1 cycle)
  - `bus_out` = latched address, `bus_oe` = all ones, `mar_we` = 1.
  - Then -> WDATA if we, else -> RWAIT.
- **WDATA** (1 cycle)
  - `bus_out[DATA_W-1:0]` = latched wdata; upper bits 0.
  - `bus_oe` = low DATA_W bits set, upper bits clear.
  - `ram_we` = 1.
  - Then -> ACK.
- **RWAIT** (READ_WAIT cycles)
  - `bus_oe` = 0 and `bus_out` = 0.
  - 4-bit counter loads READ_WAIT-1 on entry and decrements.
  - On the cycle the counter reads 0: capture `mem_rdata` into the granted port's rdata register, then -> ACK.
- **ACK** (1 cycle)
  - Assert the granted port's ack.
  - Update the round-robin last-grant.
  - Then -> IDLE.
  - The requester drops or changes req on the cycle after ack; IDLE never sees the completed request.
- Outside ADDR and WDATA, `bus_out`, `bus_oe`, `mar_we` and `ram_we` are 0.
- All pad outputs and acks are registered, so they are glitch-free for the serial/pad domain.
- A request deasserted before its ack is a protocol violation.
  - Once latched, the transaction runs to completion.
  - If req is already low in ACK, the ack is still issued.
- A requester waiting while the other is serviced sees no ack and keeps req high. There is no timeout.

## Timing
- **Reset values:** state IDLE, all outputs 0, both rdata registers 0, last grant = CPU, counter 0.
- **Reset mid-transaction** (rst_n low at any point):
  - Outputs clear asynchronously.
  - The in-flight transaction is dropped; no ack and no rdata update.
  - After rst_n returns high, the first posedge is a normal IDLE sample.
- **Write:** req sampled at edge 0. ADDR is visible in cycle 1, WDATA in cycle 2, ack in cycle 3. Occupancy is 4 cycles.
- **Read:** ADDR in cycle 1, RWAIT in cycles 2..1+READ_WAIT, ack plus rdata in cycle 2+READ_WAIT. Occupancy is 3+READ_WAIT cycles (5 at the default).
- **Back-to-back:** the next grant is sampled in the IDLE cycle after ACK. Minimum spacing between consecutive ADDR phases is 4 (write) or 3+READ_WAIT (read).
- **Worst-case wait** for a continuously requesting port: one full transaction of the other port.

## Structure
- Package `ext_mem_arb_pkg` holds:
  - `arb_state_e` (IDLE, ADDR, WDATA, RWAIT, ACK).
  - `req_id_e` (REQ_CPU, REQ_HOST).
  - The RWAIT counter width constant.
- Sub-module `rr_arb2`:
  - Combinational grant from two reqs plus a last-grant register.
  - The register updates on an `advance` pulse driven in ACK.
  - Resets to REQ_CPU.
- The FSM, latches, rdata registers and pad drive live in `ext_mem_arbiter`.

## Test plan
- Reset, then CPU write addr 0x1234, data 0xA5:
  - Cycle 1: `bus_out`=0x1234, `bus_oe`=0xFFFF, `mar_we`=1.
  - Cycle 2: `bus_out`=0x00A5, `bus_oe`=0x00FF, `ram_we`=1.
  - Cycle 3: `cpu_ack`=1.
  - `host_ack` never asserts.
- Host read addr 0x0040 with `mem_rdata`=0x3C driven during RWAIT (READ_WAIT=2):
  - `bus_oe`=0 in cycles 2-3.
  - Cycle 4: `host_ack`=1, `host_rdata`=0x3C.
  - `cpu_rdata` stays 0.
- Simultaneous CPU and host requests held high right after reset:
  - Grant order is host, CPU, host, CPU.
  - Each ack arrives exactly once per transaction.
- READ_WAIT=5: CPU read
  - `cpu_ack` arrives 7 cycles after the request edge.
  - `mem_rdata` changed before the last RWAIT cycle is not captured.
- rst_n pulsed low during the WDATA of a host write:
  - All outputs are 0 immediately, with no `host_ack`.
  - A request held through reset restarts with ADDR in the cycle after the first post-reset IDLE sample.
- Continuous CPU reads with a host write arriving mid-read:
  - The host is granted directly after the current ACK.
  - The CPU is then re-granted.
  - `busy` is low for exactly one cycle between transactions.
